// File: rtl/xb_local_arb.sv
// Input-port local switch arbiter: round-robin VC pick, wormhole lock until tail grant, dequeue pulses.
// Optional XB_LARB_BYPASS_EN: zero-bubble turnover by re-arbitrating on the tail-grant cycle.
module xb_local_arb #(
   parameter int NV          = 4,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NV-1:0] vc_req,
   input  logic [NV-1:0] vc_tail,
   input  logic          gnt,
   output logic [NV-1:0] sel,
   output logic          req_out,
   output logic [NV-1:0] vc_pop,
   output logic          err_pkt_len
);

   localparam int PW = (NV > 1) ? $clog2(NV) : 1;
   localparam logic [NV-1:0] ONE = NV'(1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_reg;
   logic [NV-1:0] sel_reg;
   logic [PW-1:0] ptr_reg;
   logic [7:0]    cnt_reg;
   logic          err_reg;

   logic [PW-1:0] win_idx;
   logic [PW-1:0] next_ptr;
   logic [PW:0]   idle_pick;
   logic [8:0]    cnt_inc;
   logic          granted;
   logic          tail_hit;

   // Returns {found, index} of the first requester at or after start, wrapping mod NV.
   function automatic logic [PW:0] rr_pick(input logic [NV-1:0] req, input logic [PW-1:0] start);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int k = NV - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % NV;
         if (req[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NV; i++) begin
         if (sel_reg[i]) win_idx = PW'(i);
      end
   end

   assign next_ptr  = (win_idx == PW'(NV - 1)) ? '0 : win_idx + PW'(1);
   assign idle_pick = rr_pick(vc_req, ptr_reg);
   assign cnt_inc   = {1'b0, cnt_reg} + 9'd1;

   assign req_out  = (state_reg == HOLD) & |(vc_req & sel_reg);
   assign granted  = gnt & req_out;
   assign tail_hit = vc_tail[win_idx];

   genvar gi;
   generate
      for (gi = 0; gi < NV; gi++) begin : g_pop
         assign vc_pop[gi] = sel_reg[gi] & granted;
      end
   endgenerate

`ifdef XB_LARB_BYPASS_EN
   logic [PW:0] byp_pick;
   assign byp_pick = rr_pick(vc_req & ~sel_reg, next_ptr);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (idle_pick[PW]) begin
                  sel_reg   <= ONE << idle_pick[PW-1:0];
                  cnt_reg   <= '0;
                  state_reg <= HOLD;
               end else begin
                  sel_reg <= '0;
               end
            end
            HOLD: begin
               // Lock is held while the winner stalls; only a grant moves the FSM.
               if (granted) begin
                  if (tail_hit) begin
                     ptr_reg <= next_ptr;
                     cnt_reg <= '0;
`ifdef XB_LARB_BYPASS_EN
                     if (byp_pick[PW]) begin
                        sel_reg <= ONE << byp_pick[PW-1:0];
                     end else begin
                        sel_reg   <= '0;
                        state_reg <= IDLE;
                     end
`else
                     sel_reg   <= '0;
                     state_reg <= IDLE;
`endif
                  end else begin
                     if (cnt_reg != 8'hFF) cnt_reg <= cnt_inc[7:0];
                     if (cnt_inc >= 9'(MAX_PKT_LEN)) err_reg <= 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign sel         = sel_reg;
   assign err_pkt_len = err_reg;

endmodule

// File: tb/tb_xb_local_arb.sv
// Directed testbench for xb_local_arb with MAX_PKT_LEN=4; expected values computed by hand.
module tb_xb_local_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] vc_req;
   logic [3:0] vc_tail;
   logic       gnt;
   logic [3:0] sel;
   logic       req_out;
   logic [3:0] vc_pop;
   logic       err_pkt_len;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   xb_local_arb #(.NV(4), .MAX_PKT_LEN(4)) dut (
      .clk(clk), .rst(rst), .vc_req(vc_req), .vc_tail(vc_tail), .gnt(gnt),
      .sel(sel), .req_out(req_out), .vc_pop(vc_pop), .err_pkt_len(err_pkt_len)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end else begin
         $display("ok   %s: %b", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; vc_req = '0; vc_tail = '0; gnt = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   logic [3:0] exp2 [10];
   logic [3:0] exp4 [4];

   initial begin
`ifdef XB_LARB_BYPASS_EN
      exp2 = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`else
      exp2 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
`endif
      exp4 = '{4'h0, 4'h0, 4'h0, 4'h1};

      // Reset state and single-requester packet
      do_reset();
      chk("rst_sel", 8'(sel), 8'h00);
      chk("rst_req", 8'(req_out), 8'h00);
      chk("rst_pop", 8'(vc_pop), 8'h00);
      chk("rst_err", 8'(err_pkt_len), 8'h00);
      vc_req = 4'b0100; vc_tail = 4'b0100; gnt = 1'b0;
      #1 chk("t1_idle_req", 8'(req_out), 8'h00);
      step();
      chk("t1_sel", 8'(sel), 8'h04);
      chk("t1_req", 8'(req_out), 8'h01);
      gnt = 1'b1;
      #1 chk("t1_pop", 8'(vc_pop), 8'h04);
      step();
      gnt = 1'b0; vc_req = 4'b1111; vc_tail = 4'b1111;
      #1 chk("t1_sel_idle", 8'(sel), 8'h00);
      chk("t1_req_idle", 8'(req_out), 8'h00);
      step();
      chk("t1_ptr3", 8'(sel), 8'h08);

      // Round-robin order with constant grant and single-flit packets
      do_reset();
      vc_req = 4'b1111; vc_tail = 4'b1111; gnt = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1 chk($sformatf("t2_pop_c%0d", c), 8'(vc_pop), 8'(exp2[c]));
         step();
      end

      // Grant in IDLE is ignored
      do_reset();
      gnt = 1'b1;
      #1 chk("t6_idle_pop", 8'(vc_pop), 8'h00);
      step();
      chk("t6_idle_sel", 8'(sel), 8'h00);

      // Locked VC stalls while another VC requests
      do_reset();
      vc_req = 4'b0010;
      step();
      chk("t3_sel", 8'(sel), 8'h02);
      gnt = 1'b1;
      #1 chk("t3_pop_f1", 8'(vc_pop), 8'h02);
      step();
      vc_req = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("t3_stall_sel%0d", c), 8'(sel), 8'h02);
         chk($sformatf("t3_stall_req%0d", c), 8'(req_out), 8'h00);
         chk($sformatf("t3_stall_pop%0d", c), 8'(vc_pop), 8'h00);
         step();
      end
      vc_req = 4'b0010;
      for (int c = 0; c < 2; c++) begin
         #1 chk($sformatf("t3_pop_f%0d", c + 2), 8'(vc_pop), 8'h02);
         step();
      end
      vc_tail = 4'b0010;
      #1 chk("t3_pop_tail", 8'(vc_pop), 8'h02);
      step();
      gnt = 1'b0; vc_tail = 4'b0000; vc_req = 4'b0001;
      #1 chk("t3_sel_after", 8'(sel), 8'h00);
      chk("t3_err", 8'(err_pkt_len), 8'h00);
      step();
      chk("t3_next_vc0", 8'(sel), 8'h01);

      // Packet-length error on a 5-flit packet, sticky afterwards
      do_reset();
      vc_req = 4'b0001;
      step();
      gnt = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         chk($sformatf("t4_err_g%0d", g + 1), 8'(err_pkt_len), 8'(exp4[g]));
      end
      vc_tail = 4'b0001;
      step();
      gnt = 1'b0;
      #1 chk("t4_err_tail", 8'(err_pkt_len), 8'h01);
      chk("t4_sel_idle", 8'(sel), 8'h00);
      step();
      gnt = 1'b1;
      step();
      chk("t4_err_next", 8'(err_pkt_len), 8'h01);

      // Reset mid-packet on VC3
      gnt = 1'b0; vc_tail = 4'b0000; vc_req = 4'b1000;
      step();
      gnt = 1'b1;
      step();
      chk("t5_sel_mid", 8'(sel), 8'h08);
      gnt = 1'b0; rst = 1'b1;
      step();
      chk("t5_sel", 8'(sel), 8'h00);
      chk("t5_req", 8'(req_out), 8'h00);
      chk("t5_err", 8'(err_pkt_len), 8'h00);
      rst = 1'b0; vc_req = 4'b1111;
      step();
      chk("t5_ptr0", 8'(sel), 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
